// File: rtl/pred_check_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// prediction scoring stage (pred_checker / pred_queue).
package pred_check_pkg;

  typedef enum logic [1:0] {
    CORRECT = 2'd0,
    MISS_T  = 2'd1,
    MISS_NT = 2'd2,
    ORPHAN  = 2'd3
  } outcome_e;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 32;

  // Increment val, holding at the all-ones value of a width-bit counter (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_v;
    max_v = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - width);
    if (val >= max_v) begin
      return max_v;
    end else begin
      return val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of pending predictions with registered full/empty/count.
// Pushes while full and pops while empty are ignored.
module pred_queue
  import pred_check_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_WD = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_WD-1:0] count_r;
  logic [CNT_WD-1:0] count_next_s;
  logic              full_r;
  logic              empty_r;
  logic              push_s;
  logic              pop_s;

  assign push_s = push && !full_r;
  assign pop_s  = pop && !empty_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_WD'(1);
      2'b01:   count_next_s = count_r - CNT_WD'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_WD'(DEPTH));
      empty_r <= (count_next_s == CNT_WD'(0));
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/pred_checker.sv
// Scores queued branch predictions against resolved outcomes with saturating counters.
// Optional PC cross-check of each popped entry is enabled by defining PRED_CHECK_PC_EN.
module pred_checker
  import pred_check_pkg::*;
#(
  parameter int Direction_SIZE = DEF_PC_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pred_valid,
  input  logic                      prediction,
  input  logic [Direction_SIZE-1:0] pred_pc,
  output logic                      pred_ready,
  input  logic                      out_valid,
  input  logic                      branch_result,
  input  logic [Direction_SIZE-1:0] out_pc,
  input  logic                      stats_clear,
  output logic [CNT_W-1:0]          total_branch,
  output logic [CNT_W-1:0]          correct_cnt,
  output logic [CNT_W-1:0]          miss_t_cnt,
  output logic [CNT_W-1:0]          miss_nt_cnt,
  output logic [CNT_W-1:0]          orphan_cnt,
  output logic                      mismatch,
  output logic [$clog2(DEPTH):0]    pending
);

`ifdef PRED_CHECK_PC_EN
  localparam int DATA_W = Direction_SIZE + 1;
`else
  localparam int DATA_W = 1;
`endif

  logic              push_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] rd_data_s;
  outcome_e          cls_s;

  logic [CNT_W-1:0]  total_r;
  logic [CNT_W-1:0]  correct_r;
  logic [CNT_W-1:0]  miss_t_r;
  logic [CNT_W-1:0]  miss_nt_r;
  logic [CNT_W-1:0]  orphan_r;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_W));
  endfunction

  assign push_s     = pred_valid && !full_s;
  assign pred_ready = !full_s;

  pred_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (wr_data_s),
    .pop     (out_valid),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (pending)
  );

  // Classify the outcome against the queue head as seen before this edge.
  always_comb begin
    cls_s = CORRECT;
    if (empty_s) begin
      cls_s = ORPHAN;
    end else if (rd_data_s[0] == branch_result) begin
      cls_s = CORRECT;
    end else if (branch_result) begin
      cls_s = MISS_T;
    end else begin
      cls_s = MISS_NT;
    end
  end

  // Statistics counters; a clear in the same cycle suppresses scoring.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      total_r   <= '0;
      correct_r <= '0;
      miss_t_r  <= '0;
      miss_nt_r <= '0;
      orphan_r  <= '0;
    end else if (out_valid) begin
      case (cls_s)
        CORRECT: begin
          total_r   <= bump(total_r);
          correct_r <= bump(correct_r);
        end
        MISS_T: begin
          total_r  <= bump(total_r);
          miss_t_r <= bump(miss_t_r);
        end
        MISS_NT: begin
          total_r   <= bump(total_r);
          miss_nt_r <= bump(miss_nt_r);
        end
        ORPHAN:  orphan_r <= bump(orphan_r);
        default: orphan_r <= orphan_r;
      endcase
    end
  end

  assign total_branch = total_r;
  assign correct_cnt  = correct_r;
  assign miss_t_cnt   = miss_t_r;
  assign miss_nt_cnt  = miss_nt_r;
  assign orphan_cnt   = orphan_r;

`ifdef PRED_CHECK_PC_EN
  logic                      mismatch_r;
  logic [Direction_SIZE-1:0] head_pc_s;

  assign wr_data_s = {pred_pc, prediction};
  assign head_pc_s = rd_data_s[DATA_W-1:1];

  // Sticky PC-mismatch flag, cleared by reset or stats_clear.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      mismatch_r <= 1'b0;
    end else if (out_valid && !empty_s && (head_pc_s != out_pc)) begin
      mismatch_r <= 1'b1;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign mismatch = mismatch_r;
`else
  logic unused_pc_s;

  assign wr_data_s   = prediction;
  assign mismatch    = 1'b0;
  assign unused_pc_s = ^{pred_pc, out_pc};
`endif

endmodule

// File: tb/tb_pred_checker.sv
// Randomized self-checking bench for pred_checker against a queue-based reference model.
module tb_pred_checker;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam logic [63:0] SAT = (64'd1 << CNT_W) - 64'd1;

  logic             clk;
  logic             reset;
  logic             pred_valid;
  logic             prediction;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_ready;
  logic             out_valid;
  logic             branch_result;
  logic [PC_W-1:0]  out_pc;
  logic             stats_clear;
  logic [CNT_W-1:0] total_branch;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] miss_t_cnt;
  logic [CNT_W-1:0] miss_nt_cnt;
  logic [CNT_W-1:0] orphan_cnt;
  logic             mismatch;
  logic [PW-1:0]    pending;

  int vectors = 0;
  int miscompares = 0;

  logic [PC_W:0] mq[$];
  logic [63:0]   m_total, m_correct, m_mt, m_mnt, m_orph;
  logic          m_mis;

  pred_checker #(
    .Direction_SIZE (PC_W),
    .DEPTH          (DEPTH),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .prediction    (prediction),
    .pred_pc       (pred_pc),
    .pred_ready    (pred_ready),
    .out_valid     (out_valid),
    .branch_result (branch_result),
    .out_pc        (out_pc),
    .stats_clear   (stats_clear),
    .total_branch  (total_branch),
    .correct_cnt   (correct_cnt),
    .miss_t_cnt    (miss_t_cnt),
    .miss_nt_cnt   (miss_nt_cnt),
    .orphan_cnt    (orphan_cnt),
    .mismatch      (mismatch),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input logic [63:0] v);
    return (v >= SAT) ? SAT : v + 64'd1;
  endfunction

  task automatic zero_model_counts();
    m_total = 64'd0; m_correct = 64'd0; m_mt = 64'd0; m_mnt = 64'd0; m_orph = 64'd0;
    m_mis = 1'b0;
  endtask

  // Applies the behavioural rules to the inputs about to be sampled.
  task automatic model_step();
    int sz;
    bit do_push;
    logic [PC_W:0] head;
    if (reset) begin
      mq.delete();
      zero_model_counts();
    end else begin
      sz = mq.size();
      do_push = pred_valid && (sz < DEPTH);
      if (out_valid) begin
        if (sz == 0) begin
          if (!stats_clear) m_orph = sat(m_orph);
        end else begin
          head = mq.pop_front();
          if (!stats_clear) begin
            m_total = sat(m_total);
            if (head[0] == branch_result) m_correct = sat(m_correct);
            else if (branch_result)       m_mt = sat(m_mt);
            else                          m_mnt = sat(m_mnt);
          end
`ifdef PRED_CHECK_PC_EN
          if (head[PC_W:1] != out_pc) m_mis = 1'b1;
`endif
        end
      end
      if (stats_clear) zero_model_counts();
      if (do_push) mq.push_back({pred_pc, prediction});
    end
  endtask

  task automatic compare_all();
    check("pred_ready",   64'(pred_ready),   64'(mq.size() < DEPTH));
    check("pending",      64'(pending),      64'(mq.size()));
    check("total_branch", 64'(total_branch), m_total);
    check("correct_cnt",  64'(correct_cnt),  m_correct);
    check("miss_t_cnt",   64'(miss_t_cnt),   m_mt);
    check("miss_nt_cnt",  64'(miss_nt_cnt),  m_mnt);
    check("orphan_cnt",   64'(orphan_cnt),   m_orph);
    check("mismatch",     64'(mismatch),     64'(m_mis));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic pv, input logic p, input logic [PC_W-1:0] ppc,
                       input logic ov, input logic br, input logic [PC_W-1:0] opc,
                       input logic clr);
    reset = 1'b0; pred_valid = pv; prediction = p; pred_pc = ppc;
    out_valid = ov; branch_result = br; out_pc = opc; stats_clear = clr;
  endtask

  logic [63:0] saved_total;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    zero_model_counts();
    cycle();
    cycle();
    check("rst_ready", 64'(pred_ready), 64'd1);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_total", 64'(total_branch), 64'd0);

    // Basic scoring: T/NT/T predicted, T/T/NT resolved.
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);  cycle();
    drive(1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);  cycle();
    drive(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0);  cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0);  cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b0);  cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 1'b0);  cycle();
    check("basic_total", 64'(total_branch), 64'd3);
    check("basic_correct", 64'(correct_cnt), 64'd1);
    check("basic_miss_t", 64'(miss_t_cnt), 64'd1);
    check("basic_miss_nt", 64'(miss_nt_cnt), 64'd1);

    // Fill and overflow.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      cycle();
      if (i == 3) check("fill_ready", 64'(pred_ready), 64'd0);
    end
    check("fill_pending", 64'(pending), 64'd4);

    // Simultaneous push and pop at full, then at two entries.
    drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100, 1'b0);  cycle();
    check("full_pushpop", 64'(pending), 64'd3);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h101, 1'b0);    cycle();
    drive(1'b1, 1'b0, 32'h210, 1'b1, 1'b1, 32'h102, 1'b0);  cycle();
    check("two_pushpop", 64'(pending), 64'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h103, 1'b0);    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h210, 1'b0);    cycle();
    check("drained", 64'(pending), 64'd0);

    // Orphan, then clear together with a pop.
    saved_total = m_total;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);      cycle();
    check("orphan_cnt_1", 64'(orphan_cnt), 64'd1);
    check("orphan_total", 64'(total_branch), saved_total);
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1);    cycle();
    check("clr_total", 64'(total_branch), 64'd0);
    check("clr_correct", 64'(correct_cnt), 64'd0);
    check("clr_orphan", 64'(orphan_cnt), 64'd0);
    check("clr_popped", 64'(pending), 64'd0);

    // PC cross-check: 0x40 predicted, 0x44 resolved.
    drive(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);     cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 1'b0);     cycle();
`ifdef PRED_CHECK_PC_EN
    check("pc_mismatch", 64'(mismatch), 64'd1);
`else
    check("pc_mismatch_off", 64'(mismatch), 64'd0);
`endif
    check("pc_scored", 64'(correct_cnt), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);      cycle(); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);      cycle();
    check("pc_cleared", 64'(mismatch), 64'd0);

    // Randomized traffic, with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      logic [PC_W-1:0] opc;
      opc = 32'h10 * 32'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) opc = mq[0][PC_W:1];
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'h10 * 32'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)), opc,
            1'($urandom_range(0, 39) == 0));
      reset = 1'($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pred_checker.md
# pred_checker

Scoring stage directly downstream of the pshare predictor. Each prediction (taken bit plus PC) is queued in order until the actual branch outcome resolves, then compared against it. The block keeps saturating counters of correct predictions, taken-mispredictions and not-taken-mispredictions, and flags outcomes that arrive with no queued prediction. The counters replace the predictor's ad-hoc error tally as the authoritative accuracy statistic.

## Interface
- `Direction_SIZE`, 32: PC width.
- `DEPTH`, 4: pending-prediction queue entries; power of two, at least 2.
- `CNT_W`, 32: width of every statistics counter.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears queue, counters and flags.
- `pred_valid`  in  1: a prediction is offered this cycle.
- `prediction`  in  1: predicted direction; 1 = taken.
- `pred_pc`  in  Direction_SIZE: PC of the predicted branch.
- `pred_ready`  out  1: queue can accept; equals `!full`.
- `out_valid`  in  1: a resolved outcome is presented; always accepted.
- `branch_result`  in  1: actual direction; 1 = taken.
- `out_pc`  in  Direction_SIZE: PC of the resolved branch.
- `stats_clear`  in  1: zeroes all counters and the sticky flag.
- `total_branch`  out  CNT_W: outcomes scored.
- `correct_cnt`  out  CNT_W: outcomes where `prediction == branch_result`.
- `miss_t_cnt`  out  CNT_W: outcomes predicted not-taken but actually taken.
- `miss_nt_cnt`  out  CNT_W: outcomes predicted taken but actually not-taken.
- `orphan_cnt`  out  CNT_W: outcomes that arrived while the queue was empty.
- `mismatch`  out  1: sticky; set on a PC mismatch (only when the PC-check macro is defined).
- `pending`  out  $clog2(DEPTH)+1: current queue occupancy.

## Operation
- Push: a prediction is written to the queue when `pred_valid && pred_ready`. When the queue is full, `pred_valid` is ignored and nothing is pushed.
- Pop and score: when `out_valid` is high and the queue is non-empty, the head entry is popped and scored in the same edge.
  - `total_branch` increments by 1.
  - Exactly one of `correct_cnt`, `miss_t_cnt`, `miss_nt_cnt` increments by 1.
- Orphan: `out_valid` with an empty queue increments `orphan_cnt` only. No other counter changes.
- Push and pop in the same cycle:
  - Both are allowed, including when the queue is full.
  - When full, `pred_ready` is 0, so no push happens even if a pop frees a slot.
  - When empty, the pop sees the old (empty) state, so the outcome is an orphan and the prediction is pushed.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `stats_clear`:
  - Zeroes all five counters and `mismatch`.
  - Queue contents are kept.
  - An outcome in the same cycle is still popped but not counted (clear wins).
- Queue pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty are determined by `pending`.

## Timing
- All outputs are registered. Reset values: `pred_ready`=1, all counters 0, `mismatch`=0, `pending`=0.
- A prediction pushed at edge N is poppable by an outcome sampled at edge N+1 or later.
- Counters reflect an outcome one cycle after the edge that sampled it (visible after edge N).
- `pred_ready` reflects occupancy after the current edge. There is no combinational path from `out_valid` to `pred_ready`.
- Reset asserted mid-operation discards all pending entries on that edge. `pred_ready` returns to 1 in the following cycle.

## Configuration
- `PRED_CHECK_PC_EN`:
  - Defined: each pop compares the head PC against `out_pc`.
  - On inequality, `mismatch` is set; the outcome is still scored by direction.
  - Undefined: the PC field is not stored in the queue and `mismatch` is tied to 0.

## Structure
- Package `pred_check_pkg` holds:
  - the outcome-class typedef `{CORRECT, MISS_T, MISS_NT, ORPHAN}`;
  - the default widths;
  - the saturating-increment function.
- Sub-module `pred_queue`: a synchronous FIFO of `{pc, prediction}` with push, pop, full, empty and count. The parent holds scoring and counters only.

## Test plan
- **Reset:** hold `reset` for 2 cycles -> `pred_ready`=1, `pending`=0, all counters 0.
- **Basic scoring:** push predictions T, NT, T at PCs 0x10, 0x20, 0x30; then apply outcomes T, T, NT -> `total_branch`=3, `correct_cnt`=1, `miss_t_cnt`=1, `miss_nt_cnt`=1.
- **Fill and overflow:** push 5 predictions with DEPTH=4 -> `pred_ready`=0 after the 4th, 5th dropped, `pending`=4.
- **Simultaneous push and pop:**
  - At full, assert `pred_valid` and `out_valid` -> `pending`=3, since no push occurs.
  - At 2 entries, assert both -> `pending` stays 2.
- **Orphan and clear:**
  - Outcome while empty -> `orphan_cnt`=1, `total_branch` unchanged.
  - Then `stats_clear` together with `out_valid` -> all counters 0 and the head entry popped.
- **PC check (macro defined):** push PC 0x40, outcome at PC 0x44 -> `mismatch`=1 and stays 1 until `stats_clear` or `reset`.
